// File: rtl/conv3x3_window_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv3x3_window_stream                                                    |
// | Streams a square image through two line buffers and emits zero-padded    |
// | 3x3 windows on an AXI-Stream master. Optional: CONV_WIN_STRIDE2_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv3x3_window_stream #(
  parameter int DATA_W  = 16,
  parameter int MAX_IMG = 128,
  parameter int SIZE_W  = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [SIZE_W-1:0]   cfg_img_size,
  input  logic                cfg_stride2,
  input  logic                cfg_start,
  output logic                busy,
  output logic                err_cfg,
  output logic                err_tlast,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [9*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser
);

  localparam logic [SIZE_W-1:0] C_MAX_IMG = SIZE_W'(MAX_IMG);
  localparam logic [SIZE_W-1:0] C_MIN_IMG = SIZE_W'(3);
  localparam logic [SIZE_W-1:0] C_ONE     = SIZE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SIZE_W-1:0]   r_size, r_vr, r_vc, r_last_pos;
  logic [DATA_W-1:0]   r_lb0 [0:MAX_IMG];
  logic [DATA_W-1:0]   r_lb1 [0:MAX_IMG];
  logic [DATA_W-1:0]   r_win [0:2][0:2];
  logic [DATA_W-1:0]   w_shift [0:2][0:2];
  logic [DATA_W-1:0]   w_col [0:2];
  logic [DATA_W-1:0]   w_pix;
  logic [9*DATA_W-1:0] w_tdata;
  logic w_cfg_s2, w_stride2, w_start_ok, w_start_bad, w_out_free;
  logic w_pad, w_adv, w_emit, w_final, w_pix_acc, w_exp_last;

`ifdef CONV_WIN_STRIDE2_EN
  logic r_stride2;
  assign w_cfg_s2  = cfg_stride2;
  assign w_stride2 = r_stride2;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)        r_stride2 <= 1'b0;
    else if (w_start_ok) r_stride2 <= cfg_stride2;
  end
`else
  logic w_unused_stride2;
  assign w_unused_stride2 = cfg_stride2;
  assign w_cfg_s2         = 1'b0;
  assign w_stride2        = 1'b0;
`endif

  assign w_start_ok  = (r_state == S_IDLE) && cfg_start &&
                       (cfg_img_size >= C_MIN_IMG) && (cfg_img_size <= C_MAX_IMG);
  assign w_start_bad = (r_state == S_IDLE) && cfg_start && !w_start_ok;
  assign w_out_free  = !m_axis_tvalid || m_axis_tready;
  assign w_pad       = (r_vr == r_size) || (r_vc == r_size);
  assign w_adv       = (r_state == S_STREAM) && (w_pad || s_axis_tvalid) && w_out_free;
  assign s_axis_tready = (r_state == S_STREAM) && !w_pad && w_out_free;
  assign w_pix_acc   = s_axis_tvalid && s_axis_tready;
  assign w_exp_last  = (r_vr == r_size - C_ONE) && (r_vc == r_size - C_ONE);
  assign w_pix       = w_pad ? '0 : s_axis_tdata;
  assign w_emit      = w_adv && (r_vr != '0) && (r_vc != '0) &&
                       (!w_stride2 || (r_vr[0] && r_vc[0]));
  assign w_final     = w_adv && (r_vr == r_size) && (r_vc == r_size);
  assign busy        = (r_state != S_IDLE);

  // Incoming column for position (vr,vc): rows vr-2, vr-1, vr
  assign w_col[0] = r_lb1[r_vc];
  assign w_col[1] = r_lb0[r_vc];
  assign w_col[2] = w_pix;

  // Border masking hides stale line-buffer and previous-row columns
  always_comb begin
    w_tdata = '0;
    for (int i = 0; i < 3; i++) begin
      w_shift[i][0] = r_win[i][1];
      w_shift[i][1] = r_win[i][2];
      w_shift[i][2] = w_col[i];
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(((i == 0) && (r_vr == C_ONE)) || ((i == 2) && (r_vr == r_size)) ||
              ((j == 0) && (r_vc == C_ONE)) || ((j == 2) && (r_vc == r_size))))
          w_tdata[(3*i+j)*DATA_W +: DATA_W] = w_shift[i][j];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nxt = S_STREAM;
      S_STREAM: if (w_final)    w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_out_free) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb1[r_vc] <= w_col[1];
      r_lb0[r_vc] <= w_pix;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_size        <= '0;
      r_vr          <= '0;
      r_vc          <= '0;
      r_last_pos    <= '0;
      err_cfg       <= 1'b0;
      err_tlast     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_size     <= cfg_img_size;
        r_vr       <= '0;
        r_vc       <= '0;
        // Even N at stride 2 ends on centre N-2, i.e. position N-1
        r_last_pos <= (w_cfg_s2 && !cfg_img_size[0]) ? cfg_img_size - C_ONE : cfg_img_size;
        err_cfg    <= 1'b0;
        err_tlast  <= 1'b0;
      end else if (w_start_bad) begin
        err_cfg <= 1'b1;
      end
      if (w_adv) begin
        r_win <= w_shift;
        if (r_vc == r_size) begin
          r_vc <= '0;
          r_vr <= r_vr + C_ONE;
        end else begin
          r_vc <= r_vc + C_ONE;
        end
      end
      if (w_pix_acc && (s_axis_tlast != w_exp_last))
        err_tlast <= 1'b1;
      if (w_emit) begin
        m_axis_tdata  <= w_tdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (r_vr == r_last_pos) && (r_vc == r_last_pos);
        m_axis_tuser  <= (r_vr == C_ONE) && (r_vc == C_ONE);
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv3x3_window_stream                                                 |
// | Scoreboard bench: windows from a direct-indexing image model vs the DUT. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv3x3_window_stream;
  localparam int DW = 16;
  localparam int MAXI = 16;
  localparam int SW = 5;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [SW-1:0] cfg_img_size = '0;
  logic          cfg_stride2 = 1'b0;
  logic          cfg_start = 1'b0;
  logic          busy, err_cfg, err_tlast;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [WW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast, m_tuser;

  conv3x3_window_stream #(.DATA_W(DW), .MAX_IMG(MAXI), .SIZE_W(SW)) dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_img_size(cfg_img_size), .cfg_stride2(cfg_stride2), .cfg_start(cfg_start),
    .busy(busy), .err_cfg(err_cfg), .err_tlast(err_tlast),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    bit            last;
    bit            user;
  } win_t;

  win_t          exp_q[$];
  win_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            win_seen = 0;
  int            busy_cyc = 0;
  int            ready_mode = 0;
  bit            sb_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic [WW-1:0] first_data = '0;
  logic [WW-1:0] last_data = '0;

  task automatic check_val(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [WW-1:0] v;
    v = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return v;
  endfunction

  // Reference: every centre of the image in raster order, neighbours read straight from the image
  task automatic push_expected(input int n, input bit st2, input int pix[$]);
    win_t tmp[$];
    win_t w;
    int   rr, cc;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        if (st2 && (((r % 2) != 0) || ((c % 2) != 0))) continue;
        w.data = '0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            rr = r + i - 1;
            cc = c + j - 1;
            if (rr >= 0 && rr < n && cc >= 0 && cc < n)
              w.data[(3*i+j)*DW +: DW] = DW'(pix[rr*n+cc]);
          end
        end
        w.user = (r == 0) && (c == 0);
        w.last = 1'b0;
        tmp.push_back(w);
      end
    end
    tmp[tmp.size()-1].last = 1'b1;
    foreach (tmp[k]) exp_q.push_back(tmp[k]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cyc++;
    end
  end

  // Monitor: a handshake seen at the negedge completes on the following rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (aresetn && sb_en) begin
        if (prev_stall) begin
          check_val("hold_valid", WW'(m_tvalid), WW'(1));
          check_val("hold_data", m_tdata, prev_data);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: actual=%0h required=none", m_tdata);
          end else begin
            mon_e = exp_q.pop_front();
            check_val("win_data", m_tdata, mon_e.data);
            check_val("win_flags", WW'({m_tlast, m_tuser}), WW'({mon_e.last, mon_e.user}));
          end
          win_seen++;
          if (m_tuser) first_data = m_tdata;
          if (m_tlast) last_data = m_tdata;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic run_image(input int n, input bit st2, input bit rnd, input bit gaps,
                           input int bad_idx, input bit chk_busy);
    int pix[$];
    int q0, w0, b0, exp_n, guard;
    bit st2_eff;
`ifdef CONV_WIN_STRIDE2_EN
    st2_eff = st2;
`else
    st2_eff = 1'b0;
`endif
    for (int k = 0; k < n * n; k++)
      pix.push_back(rnd ? int'($urandom_range(0, 65535)) : k + 1);
    q0 = exp_q.size();
    push_expected(n, st2_eff, pix);
    exp_n = exp_q.size() - q0;
    w0 = win_seen;
    b0 = busy_cyc;
    @(posedge clk);
    #1;
    cfg_img_size = SW'(n);
    cfg_stride2  = st2;
    cfg_start    = 1'b1;
    s_tvalid     = 1'b1;
    s_tdata      = DW'(pix[0]);
    s_tlast      = (n * n - 1 == 0) || (bad_idx == 0);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    check_val("busy_rise", WW'(busy), WW'(1));
    for (int k = 0; k < n * n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
          s_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = DW'(pix[k]);
        s_tlast  = (k == n * n - 1) || (k == bad_idx);
      end
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!s_tready && guard < 2000);
      if (!s_tready) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: actual=pixel %0d not accepted required=accepted", k);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    guard = 0;
    while (busy && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_val("busy_fall", WW'(busy), WW'(0));
    check_val("win_count", WW'(win_seen - w0), WW'(exp_n));
    check_val("queue_empty", WW'(exp_q.size()), WW'(0));
    if (chk_busy) check_val("busy_cycles", WW'(busy_cyc - b0), WW'((n + 1) * (n + 1) + 1));
    check_val("err_cfg_clear", WW'(err_cfg), WW'(0));
    check_val("err_tlast", WW'(err_tlast), WW'(bad_idx >= 0));
  endtask

  task automatic bad_cfg(input int n);
    @(posedge clk);
    #1;
    cfg_img_size = SW'(n);
    cfg_start    = 1'b1;
    s_tvalid     = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("cfg_reject_idle", WW'({busy, s_tready}), WW'(0));
    end
    check_val("err_cfg_set", WW'(err_cfg), WW'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check_val(nm, WW'({busy, err_cfg, err_tlast, s_tready, m_tvalid, m_tlast, m_tuser}), WW'(0));
    check_val("reset_tdata", m_tdata, '0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    sb_en   = 1'b1;

    ready_mode = 0;
    run_image(3, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    check_val("n3_first_window", first_data, pack9(0, 0, 0, 0, 1, 2, 0, 4, 5));
    check_val("n3_last_window", last_data, pack9(5, 6, 0, 8, 9, 0, 0, 0, 0));

    ready_mode = 1;
    run_image(8, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_image(5, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_image(4, 1'b0, 1'b1, 1'b1, 9, 1'b0);
    bad_cfg(2);
    bad_cfg(MAXI + 1);
    run_image(MAXI, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    run_image(7, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    run_image(6, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // Abandon an N=6 image part-way through with a reset pulse
    sb_en = 1'b0;
    @(posedge clk);
    #1;
    cfg_img_size = SW'(6);
    cfg_stride2  = 1'b0;
    cfg_start    = 1'b1;
    s_tvalid     = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      s_tdata = DW'($urandom_range(1, 65535));
    end
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;

    ready_mode = 0;
    run_image(3, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    check_val("post_reset_first", first_data, pack9(0, 0, 0, 0, 1, 2, 0, 4, 5));
    check_val("post_reset_last", last_data, pack9(5, 6, 0, 8, 9, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
